divisor_seq: RTL and testbench
==============================

# divisor_seq

Parametrised sequential restoring divider with unsigned and signed modes, a start/busy/done handshake and divide-by-zero detection. Generalises the 4-bit A/Q shift-subtract register pair into a self-contained N-bit datapath with its own control FSM. Sits beside the ALU as a multi-cycle functional unit: the host launches one division, then reads quotient and remainder when `done` pulses.

## Interface
- `N`, default 8: operand, quotient and remainder width; N ≥ 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launch request; sampled only in state OCIOSO.
- `sinal` input 1: 0 = unsigned, 1 = two's-complement signed; sampled with `start`.
- `dividendo` input N: dividend; sampled with `start`.
- `divisor` input N: divisor; sampled with `start`.
- `quociente` output N: quotient; registered, held until next accepted `start`.
- `resto` output N: remainder; registered, held until next accepted `start`.
- `busy` output 1: high from the edge after accepted `start` until the result is published.
- `done` output 1: one-cycle pulse when the result is valid.
- `div_zero` output 1: registered; set with `done` when divisor = 0, cleared on next accepted `start`.

## Operation
- Reset (asynchronous, whenever `rst_n` = 0, including mid-operation): state OCIOSO; `quociente`, `resto`, `busy`, `done`, `div_zero` all 0; internal A (N+1 bits), Q (N bits), B (N bits), counter, and sign flags cleared.
- States: OCIOSO → CARGA → CALC (N cycles) → AJUSTE → FIM → OCIOSO. Divisor = 0 path: CARGA → FIM.
- OCIOSO: on `start` = 1, latch `dividendo`, `divisor`, `sinal`; clear `div_zero`; go to CARGA. `start` in any other state is ignored.
- CARGA: in signed mode, record sign_q = sign(dividendo) XOR sign(divisor) and sign_r = sign(dividendo); replace each operand with its magnitude, treated as an N-bit unsigned value. In unsigned mode, both signs are 0. Load A = 0, Q = |dividendo|, B = |divisor|, counter = N.
  - If B = 0: set `quociente` = all ones and `resto` = latched raw `dividendo`. Set `div_zero` = 1. Go to FIM.
- CALC, once per cycle: {A,Q} shifted left by 1; trial = A − {0,B} in N+1 bits. If trial ≥ 0, then A = trial and Q[0] = 1; otherwise A keeps the shifted value and Q[0] = 0. Decrement counter; leave CALC after N iterations.
- AJUSTE: `quociente` = sign_q ? −Q : Q; `resto` = sign_r ? −A[N−1:0] : A[N−1:0]. Negation is N-bit two's complement and wraps.
- Quotient truncates toward zero. The remainder takes the dividend's sign. Overflow case −2^(N−1) / −1 yields `quociente` = 2^(N−1) bit pattern (wraps to itself) and `resto` = 0, with no flag.
- FIM: `done` = 1, `busy` = 0; unconditionally go to OCIOSO.

## Timing
- `start` accepted at edge k; `busy` is high after edge k+1.
- Normal path: CALC occupies edges k+2 … k+N+1, AJUSTE at k+N+2. `done` is high and results are valid in the cycle after edge k+N+2. Latency is N+2 cycles (10 for N = 8).
- Zero-divisor path: results and `div_zero` valid, `done` high, in the cycle after edge k+2.
- `busy` and `done` are never high together. `done` is exactly one cycle wide.
- Earliest next `start` accepted is on the edge after `done` (the OCIOSO cycle). Back-to-back throughput is one division per N+4 cycles.
- Input changes after edge k do not affect the running division.

## Test plan
- N=8, unsigned, 200 / 7 → `quociente` = 28, `resto` = 4, `done` pulse exactly 10 cycles after `start`, `busy` high for cycles 1–9.
- N=8, unsigned, 13 / 0 → `div_zero` = 1, `quociente` = 0xFF, `resto` = 13, `done` 2 cycles after `start`. The next valid division clears `div_zero`.
- N=8, signed, 0xF9 (−7) / 0x02 → `quociente` = 0xFD (−3), `resto` = 0xFF (−1); also 7 / −2 → 0xFD, 0x01.
- N=8, signed, 0x80 / 0xFF → `quociente` = 0x80, `resto` = 0; unsigned 255 / 1 → 255, 0.
- Pulse `start` with different operands while `busy` → ignored, and the first result is unchanged. Toggle `dividendo` mid-operation → no effect.
- Assert `rst_n` = 0 during CALC iteration 4 → all outputs 0 immediately. After release, 100 / 10 completes with 10, 0 at the nominal latency.
- N=4 instance, unsigned, 15 / 4 → `quociente` = 3, `resto` = 3, latency 6 cycles.

Source files
------------

// File: rtl/divisor_seq_if.sv
// Host-side bundle for the sequential divider: launch operands in,
// quotient/remainder and start/busy/done status out.
interface divisor_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic         sinal;
    logic [N-1:0] dividendo;
    logic [N-1:0] divisor;
    logic [N-1:0] quociente;
    logic [N-1:0] resto;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        output start, sinal, dividendo, divisor,
        input  quociente, resto, busy, done, div_zero
    );

    modport slave (
        input  start, sinal, dividendo, divisor,
        output quociente, resto, busy, done, div_zero
    );
endinterface

// File: rtl/divisor_seq.sv
// N-bit restoring shift-subtract divider, unsigned or two's-complement signed,
// one quotient bit per cycle with start/busy/done handshake and zero-divisor flag.
module divisor_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    divisor_seq_if.slave   bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        OCIOSO,
        CARGA,
        CALC,
        AJUSTE,
        FIM
    } state_t;

    state_t         r_state, w_state_next;
    logic           r_sinal, w_sinal_next;
    logic [N-1:0]   r_dvd, w_dvd_next;
    logic [N-1:0]   r_dvs, w_dvs_next;
    logic [N:0]     r_a, w_a_next;
    logic [N-1:0]   r_q, w_q_next;
    logic [N-1:0]   r_b, w_b_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic           r_sq, w_sq_next;
    logic           r_sr, w_sr_next;
    logic [N-1:0]   r_quo, w_quo_next;
    logic [N-1:0]   r_rem, w_rem_next;
    logic           r_busy, w_busy_next;
    logic           r_done, w_done_next;
    logic           r_dz, w_dz_next;

    logic [N-1:0]   w_dvd_mag;
    logic [N-1:0]   w_dvs_mag;
    logic [N+1:0]   w_a_sh;
    logic           w_ge;
    logic [N:0]     w_trial;

    // Magnitudes are taken as N-bit unsigned, so -2^(N-1) maps to 2^(N-1) exactly.
    assign w_dvd_mag = (r_sinal && r_dvd[N-1]) ? -r_dvd : r_dvd;
    assign w_dvs_mag = (r_sinal && r_dvs[N-1]) ? -r_dvs : r_dvs;

    assign w_a_sh  = {r_a, r_q[N-1]};
    assign w_ge    = (w_a_sh >= {2'b00, r_b});
    assign w_trial = w_a_sh[N:0] - {1'b0, r_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCIOSO;
            r_sinal <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sinal <= w_sinal_next;
            r_dvd   <= w_dvd_next;
            r_dvs   <= w_dvs_next;
            r_a     <= w_a_next;
            r_q     <= w_q_next;
            r_b     <= w_b_next;
            r_cnt   <= w_cnt_next;
            r_sq    <= w_sq_next;
            r_sr    <= w_sr_next;
            r_quo   <= w_quo_next;
            r_rem   <= w_rem_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_dz    <= w_dz_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sinal_next = r_sinal;
        w_dvd_next   = r_dvd;
        w_dvs_next   = r_dvs;
        w_a_next     = r_a;
        w_q_next     = r_q;
        w_b_next     = r_b;
        w_cnt_next   = r_cnt;
        w_sq_next    = r_sq;
        w_sr_next    = r_sr;
        w_quo_next   = r_quo;
        w_rem_next   = r_rem;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_dz_next    = r_dz;

        case (r_state)
            OCIOSO: begin
                if (bus.start) begin
                    w_dvd_next   = bus.dividendo;
                    w_dvs_next   = bus.divisor;
                    w_sinal_next = bus.sinal;
                    w_dz_next    = 1'b0;
                    w_state_next = CARGA;
                end
            end
            CARGA: begin
                w_sq_next   = r_sinal & (r_dvd[N-1] ^ r_dvs[N-1]);
                w_sr_next   = r_sinal & r_dvd[N-1];
                w_a_next    = '0;
                w_q_next    = w_dvd_mag;
                w_b_next    = w_dvs_mag;
                w_cnt_next  = CW'(N);
                w_busy_next = 1'b1;
                if (w_dvs_mag == '0) begin
                    w_quo_next   = '1;
                    w_rem_next   = r_dvd;
                    w_state_next = FIM;
                end else begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                w_a_next   = w_ge ? w_trial : w_a_sh[N:0];
                w_q_next   = {r_q[N-2:0], w_ge};
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next = AJUSTE;
                end
            end
            AJUSTE: begin
                w_quo_next   = r_sq ? -r_q : r_q;
                w_rem_next   = r_sr ? -r_a[N-1:0] : r_a[N-1:0];
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = FIM;
            end
            FIM: begin
                // B stays zero only on the zero-divisor path, which publishes here.
                if (r_b == '0) begin
                    w_done_next = 1'b1;
                    w_busy_next = 1'b0;
                    w_dz_next   = 1'b1;
                end
                w_state_next = OCIOSO;
            end
            default: begin
                w_state_next = OCIOSO;
            end
        endcase
    end

    assign bus.quociente = r_quo;
    assign bus.resto     = r_rem;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_divisor_seq.sv
// Directed bench for divisor_seq: hand-computed quotient/remainder vectors,
// latency, busy/done shape, zero divisor, ignored start, mid-run reset, N=4.
module tb_divisor_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    divisor_seq_if #(.N(8)) bus8 ();
    divisor_seq_if #(.N(4)) bus4 ();

    divisor_seq #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    divisor_seq #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        bus8.start     = 1'b1;
        bus8.sinal     = s;
        bus8.dividendo = a;
        bus8.divisor   = b;
        @(posedge clk); #1;
        bus8.start     = 1'b0;
    endtask

    task automatic wait_done8(input bit disturb, output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            if (disturb && c == 3) begin
                bus8.start     = 1'b1;
                bus8.dividendo = 8'd50;
                bus8.divisor   = 8'd5;
            end
            if (disturb && c == 4) bus8.start = 1'b0;
            if (disturb && c == 6) bus8.dividendo = 8'hAA;
            @(posedge clk); #1;
            if (bus8.done) begin
                lat = c;
                if (bus8.busy) busy_bad++;
                break;
            end
            if (!bus8.busy) busy_bad++;
        end
    endtask

    task automatic div8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat, input bit disturb);
        int lat;
        int busy_bad;
        launch8(s, a, b);
        wait_done8(disturb, lat, busy_bad);
        $display("%s: s=%0d %0h/%0h -> q=%0h r=%0h dz=%0d lat=%0d (exp q=%0h r=%0h dz=%0d lat=%0d)",
                 tag, s, a, b, bus8.quociente, bus8.resto, bus8.div_zero, lat, eq, er, edz, elat);
        chk({tag, ".lat"},  lat, elat);
        chk({tag, ".quo"},  {24'd0, bus8.quociente}, {24'd0, eq});
        chk({tag, ".rem"},  {24'd0, bus8.resto}, {24'd0, er});
        chk({tag, ".dz"},   {31'd0, bus8.div_zero}, {31'd0, edz});
        chk({tag, ".busy"}, busy_bad, 0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        int lat4;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.sinal = 1'b0; bus8.dividendo = '0; bus8.divisor = '0;
        bus4.start = 1'b0; bus4.sinal = 1'b0; bus4.dividendo = '0; bus4.divisor = '0;
        #3;
        chk("rst.quo",  {24'd0, bus8.quociente}, 32'd0);
        chk("rst.rem",  {24'd0, bus8.resto}, 32'd0);
        chk("rst.busy", {31'd0, bus8.busy}, 32'd0);
        chk("rst.done", {31'd0, bus8.done}, 32'd0);
        chk("rst.dz",   {31'd0, bus8.div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        div8("u200_7",   1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 10, 1'b0);
        div8("u13_0",    1'b0, 8'd13,  8'd0,   8'hFF,  8'd13,  1'b1, 2,  1'b0);
        div8("u100_9",   1'b0, 8'd100, 8'd9,   8'd11,  8'd1,   1'b0, 10, 1'b0);
        div8("sm7_2",    1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 10, 1'b0);
        div8("s7_m2",    1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 10, 1'b0);
        div8("s80_m1",   1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 10, 1'b0);
        div8("u255_1",   1'b0, 8'hFF,  8'h01,  8'hFF,  8'h00,  1'b0, 10, 1'b0);
        div8("ign200_7", 1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 10, 1'b1);

        // Reset lands during the fourth CALC iteration of 100/3.
        launch8(1'b0, 8'd100, 8'd3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst.busy", {31'd0, bus8.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        $display("midrst: q=%0h r=%0h busy=%0d done=%0d dz=%0d (exp all 0)",
                 bus8.quociente, bus8.resto, bus8.busy, bus8.done, bus8.div_zero);
        chk("midrst.quo",  {24'd0, bus8.quociente}, 32'd0);
        chk("midrst.rem",  {24'd0, bus8.resto}, 32'd0);
        chk("midrst.busy", {31'd0, bus8.busy}, 32'd0);
        chk("midrst.done", {31'd0, bus8.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        div8("u100_10",  1'b0, 8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 10, 1'b0);

        // N=4 instance: 15 / 4.
        @(posedge clk); #1;
        bus4.start     = 1'b1;
        bus4.dividendo = 4'd15;
        bus4.divisor   = 4'd4;
        @(posedge clk); #1;
        bus4.start     = 1'b0;
        lat4 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus4.done) begin
                lat4 = c;
                break;
            end
        end
        $display("n4_15_4: q=%0d r=%0d lat=%0d (exp q=3 r=3 lat=6)", bus4.quociente, bus4.resto, lat4);
        chk("n4.lat", lat4, 6);
        chk("n4.quo", {28'd0, bus4.quociente}, 32'd3);
        chk("n4.rem", {28'd0, bus4.resto}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
